// File: rtl/spascharm_pkg.sv
// Constants shared by the trigger/cycle block packer and the FIFO unpacker,
// so both ends of the byte FIFO agree on framing.
package spascharm_pkg;

  localparam logic [7:0] HDR_TRIG            = 8'hFF;
  localparam logic [7:0] HDR_CYCLE           = 8'hBF;
  localparam int         TRIG_PAYLOAD_BYTES  = 9;
  localparam int         CYCLE_PAYLOAD_BYTES = 3;
  localparam int         PAYLOAD_BITS        = 6;
  localparam int         CNT_W               = 4;

  typedef enum logic [1:0] {
    UNPACK_HUNT = 2'd0,
    UNPACK_TPAY = 2'd1,
    UNPACK_CPAY = 2'd2
  } unpack_state_e;

endpackage

// File: rtl/fifo_unpack_rec_assemble.sv
// Shadow assembly of 6-bit payload groups into the number/time fields.
// Outputs are the merged next values so the caller can capture a record on the final byte.
module rec_assemble
  import spascharm_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] cnt_i,
  input  logic [5:0]       grp_i,
  output logic [17:0]      num_o,
  output logic [35:0]      time_o
);

  logic [17:0] num_q, num_d;
  logic [35:0] time_q, time_d;

  always_comb begin
    num_d  = num_q;
    time_d = time_q;
    if (clear_i) begin
      num_d  = '0;
      time_d = '0;
    end else if (load_i) begin
      // Group k lands at bit 6k of num, groups 3..8 land at bit 6(k-3) of time.
      for (int k = 0; k < 3; k++) begin
        if (cnt_i == CNT_W'(k)) num_d[PAYLOAD_BITS*k +: PAYLOAD_BITS] = grp_i;
      end
      for (int k = 0; k < 6; k++) begin
        if (cnt_i == CNT_W'(k + 3)) time_d[PAYLOAD_BITS*k +: PAYLOAD_BITS] = grp_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      num_q  <= '0;
      time_q <= '0;
    end else begin
      num_q  <= num_d;
      time_q <= time_d;
    end
  end

  assign num_o  = num_d;
  assign time_o = time_d;

endmodule

// File: rtl/fifo_unpack.sv
// Reads framed trigger/cycle blocks from a standard (registered-output) byte FIFO,
// validates framing and presents one parallel record at a time on valid/ready.
// Handshake: a record transfers on any clock edge where rec_valid && rec_ready; rec_* hold while rec_valid=1.
module fifo_unpack
  import spascharm_pkg::*;
#(
  parameter int ERRW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      fifo_data,
  input  logic            fifo_empty,
  output logic            fifo_rd,
  output logic            rec_valid,
  input  logic            rec_ready,
  output logic            rec_trig,
  output logic [17:0]     rec_num,
  output logic [35:0]     rec_time,
  output logic [ERRW-1:0] err_cnt,
  output logic [1:0]      dbg_state
);

  localparam logic [CNT_W-1:0] TRIG_LAST  = CNT_W'(TRIG_PAYLOAD_BYTES - 1);
  localparam logic [CNT_W-1:0] CYCLE_LAST = CNT_W'(CYCLE_PAYLOAD_BYTES - 1);

  unpack_state_e    state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             inflight_q;
  logic             rec_valid_q, rec_trig_q;
  logic [17:0]      rec_num_q;
  logic [35:0]      rec_time_q;
  logic [ERRW-1:0]  err_q;

  logic             is_trig_hdr, is_cycle_hdr, byte_ok, in_payload, last_byte;
  logic             stop, asm_load, asm_clear, err_inc;
  unpack_state_e    hdr_state;
  logic [17:0]      asm_num;
  logic [35:0]      asm_time;

  assign is_trig_hdr  = (fifo_data == HDR_TRIG);
  assign is_cycle_hdr = (fifo_data == HDR_CYCLE);
  assign byte_ok      = (fifo_data[7:6] == 2'b00);
  assign in_payload   = inflight_q && (state_q != UNPACK_HUNT);
  assign last_byte    = ((state_q == UNPACK_TPAY) && (cnt_q == TRIG_LAST)) ||
                        ((state_q == UNPACK_CPAY) && (cnt_q == CYCLE_LAST));

  // Do not fetch past the final payload byte: the record it completes occupies the output next cycle.
  assign stop    = inflight_q && last_byte;
  assign fifo_rd = !rst && !fifo_empty && !rec_valid_q && !stop;

  assign asm_load  = in_payload && byte_ok;
  assign asm_clear = inflight_q && (is_trig_hdr || is_cycle_hdr);
  assign err_inc   = inflight_q &&
                     (((state_q == UNPACK_HUNT) && !is_trig_hdr && !is_cycle_hdr) ||
                      ((state_q != UNPACK_HUNT) && !byte_ok));

  always_comb begin
    hdr_state = UNPACK_HUNT;
    if (is_trig_hdr)       hdr_state = UNPACK_TPAY;
    else if (is_cycle_hdr) hdr_state = UNPACK_CPAY;
  end

  rec_assemble u_asm (
    .clk     (clk),
    .rst     (rst),
    .clear_i (asm_clear),
    .load_i  (asm_load),
    .cnt_i   (cnt_q),
    .grp_i   (fifo_data[5:0]),
    .num_o   (asm_num),
    .time_o  (asm_time)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= UNPACK_HUNT;
      cnt_q       <= '0;
      inflight_q  <= 1'b0;
      rec_valid_q <= 1'b0;
      rec_trig_q  <= 1'b0;
      rec_num_q   <= '0;
      rec_time_q  <= '0;
      err_q       <= '0;
    end else begin
      inflight_q <= fifo_rd;
      if (rec_valid_q && rec_ready) rec_valid_q <= 1'b0;
      if (err_inc && (err_q != {ERRW{1'b1}})) err_q <= err_q + ERRW'(1);
      if (inflight_q) begin
        case (state_q)
          UNPACK_HUNT: begin
            state_q <= hdr_state;
            cnt_q   <= '0;
          end
          UNPACK_TPAY, UNPACK_CPAY: begin
            if (!byte_ok) begin
              // A header in place of payload starts a new block at once.
              state_q <= hdr_state;
              cnt_q   <= '0;
            end else if (last_byte) begin
              state_q     <= UNPACK_HUNT;
              cnt_q       <= '0;
              rec_valid_q <= 1'b1;
              rec_trig_q  <= (state_q == UNPACK_TPAY);
              rec_num_q   <= asm_num;
              rec_time_q  <= (state_q == UNPACK_TPAY) ? asm_time : 36'd0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          default: begin
            state_q <= UNPACK_HUNT;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign rec_valid = rec_valid_q;
  assign rec_trig  = rec_trig_q;
  assign rec_num   = rec_num_q;
  assign rec_time  = rec_time_q;
  assign err_cnt   = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fifo_unpack.sv
// Bench for fifo_unpack: byte-FIFO model feeding the DUT, stream-level reference
// model filling an expected-record queue, and a monitor popping it on each handshake.
module tb_fifo_unpack;

  localparam int ERRW = 10;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [7:0]      fifo_data = 8'h00;
  logic            fifo_empty = 1'b1;
  logic            fifo_rd;
  logic            rec_valid;
  logic            rec_ready = 1'b0;
  logic            rec_trig;
  logic [17:0]     rec_num;
  logic [35:0]     rec_time;
  logic [ERRW-1:0] err_cnt;
  logic [1:0]      dbg_state;

  fifo_unpack #(.ERRW(ERRW)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_data  (fifo_data),
    .fifo_empty (fifo_empty),
    .fifo_rd    (fifo_rd),
    .rec_valid  (rec_valid),
    .rec_ready  (rec_ready),
    .rec_trig   (rec_trig),
    .rec_num    (rec_num),
    .rec_time   (rec_time),
    .err_cnt    (err_cnt),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [54:0] exp_q[$];
  logic [7:0]  fifo_q[$];
  bit          stall = 1'b0;
  bit          rand_ready = 1'b0;
  bit          rand_stall = 1'b0;

  // reference model state: 0 hunting, 1 trigger payload, 2 cycle payload
  int          m_mode = 0;
  logic [5:0]  m_grp[$];
  int          m_err = 0;

  logic [54:0] last_rec = '0;
  logic [54:0] held;
  bit          hold_pending = 1'b0;

  int          cyc = 0;
  bit          span_arm = 1'b0;
  int          rd_first = -1;
  int          rd_last = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_reset();
    m_mode = 0;
    m_grp.delete();
    m_err = 0;
    exp_q.delete();
  endtask

  task automatic model_feed(input logic [7:0] b);
    int need;
    logic [17:0] n;
    logic [35:0] t;
    if (m_mode != 0 && b[7:6] == 2'b00) begin
      m_grp.push_back(b[5:0]);
      need = (m_mode == 1) ? 9 : 3;
      if (m_grp.size() == need) begin
        n = '0;
        t = '0;
        for (int k = 0; k < need; k++) begin
          if (k < 3) n = n | (18'(m_grp[k]) << (6 * k));
          else       t = t | (36'(m_grp[k]) << (6 * (k - 3)));
        end
        exp_q.push_back({(m_mode == 1), n, t});
        m_mode = 0;
        m_grp.delete();
      end
    end else begin
      if (m_mode != 0 || (b != 8'hFF && b != 8'hBF)) begin
        if (m_err < (1 << ERRW) - 1) m_err++;
      end
      m_mode = (b == 8'hFF) ? 1 : (b == 8'hBF) ? 2 : 0;
      m_grp.delete();
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic push_byte(input logic [7:0] b);
    fifo_q.push_back(b);
    model_feed(b);
  endtask

  task automatic push_block(input bit trig, input logic [17:0] num, input logic [35:0] t);
    logic [5:0] g;
    int cnt;
    cnt = trig ? 9 : 3;
    push_byte(trig ? 8'hFF : 8'hBF);
    for (int k = 0; k < cnt; k++) begin
      if (k < 3) g = num[6*k +: 6];
      else       g = t[6*(k-3) +: 6];
      push_byte({2'b00, g});
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((fifo_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) begin
      errors++;
      $display("FAIL idle_timeout fifo_left=%0d records_left=%0d", fifo_q.size(), exp_q.size());
    end
    repeat (4) step();
  endtask

  // ---------------- FIFO model (registered output) ----------------
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rd) begin
      if (fifo_empty) begin
        errors++;
        $display("FAIL read_while_empty actual=1 required=0");
      end
      if (fifo_q.size() != 0) fifo_data <= fifo_q.pop_front();
      if (span_arm) begin
        if (rd_first < 0) rd_first = cyc;
        rd_last = cyc;
      end
    end
  end

  always @(negedge clk) fifo_empty = stall || (fifo_q.size() == 0);

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) rec_ready = ($urandom_range(0, 1) == 1);
      if (rand_stall) stall = ($urandom_range(0, 3) == 0);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        check("hold_valid", 64'(rec_valid), 64'd1);
        check("hold_fields", 64'({rec_trig, rec_num, rec_time}), 64'(held));
      end
      hold_pending = 1'b0;
      if (rec_valid) begin
        if (rec_ready) begin
          last_rec = {rec_trig, rec_num, rec_time};
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_record actual=%h required=none", last_rec);
          end else begin
            check("record", 64'(last_rec), 64'(exp_q.pop_front()));
          end
        end else begin
          hold_pending = 1'b1;
          held = {rec_trig, rec_num, rec_time};
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    repeat (2) step();
    push_byte(8'hFF);          // visible to the DUT while reset is held; must not be read
    step();
    step();
    check("reset_fifo_rd", 64'(fifo_rd), 64'd0);
    check("reset_rec_valid", 64'(rec_valid), 64'd0);
    check("reset_rec_trig", 64'(rec_trig), 64'd0);
    check("reset_rec_num", 64'(rec_num), 64'd0);
    check("reset_rec_time", 64'(rec_time), 64'd0);
    check("reset_err_cnt", 64'(err_cnt), 64'd0);
    fifo_q.delete();
    model_reset();
    step();
    rst = 1'b0;
    step();

    // single trigger block with its hand-computed record
    rec_ready = 1'b1;
    push_byte(8'hFF);
    for (int k = 1; k <= 9; k++) push_byte(8'(k));
    wait_idle(200);
    check("trig_directed", 64'(last_rec), 64'({1'b1, 18'h03081, 36'h2481C6144}));
    check("trig_err_cnt", 64'(err_cnt), 64'd0);

    // cycle block followed immediately by a trigger block: 14 reads in 16 cycles
    span_arm = 1'b1;
    rd_first = -1;
    push_block(1'b0, 18'h0103F, 36'd0);
    push_block(1'b1, 18'($urandom), {4'($urandom), 32'($urandom)});
    wait_idle(200);
    span_arm = 1'b0;
    check("b2b_read_span", 64'(rd_last - rd_first + 1), 64'd16);
    check("b2b_err_cnt", 64'(err_cnt), 64'(m_err));

    // backpressure with a second block waiting in the FIFO
    rec_ready = 1'b0;
    push_block(1'b1, 18'($urandom), {4'($urandom), 32'($urandom)});
    for (int n = 0; n < 100 && !rec_valid; n++) step();
    check("bp_valid_seen", 64'(rec_valid), 64'd1);
    push_block(1'b1, 18'($urandom), {4'($urandom), 32'($urandom)});
    for (int n = 0; n < 20; n++) begin
      step();
      check("bp_no_read", 64'(fifo_rd), 64'd0);
    end
    rec_ready = 1'b1;
    wait_idle(200);

    // empty toggled every other cycle during a trigger block
    push_byte(8'hFF);
    for (int k = 1; k <= 9; k++) push_byte(8'(k));
    for (int n = 0; n < 40; n++) begin
      stall = ~stall;
      step();
    end
    stall = 1'b0;
    wait_idle(200);
    check("stall_record", 64'(last_rec), 64'({1'b1, 18'h03081, 36'h2481C6144}));

    // reset after four payload bytes; the rest of the block arrives afterwards
    push_byte(8'hFF);
    for (int k = 1; k <= 4; k++) push_byte(8'(k));
    wait_idle(100);
    rst = 1'b1;
    step();
    step();
    check("midrst_rec_valid", 64'(rec_valid), 64'd0);
    check("midrst_rec_trig", 64'(rec_trig), 64'd0);
    check("midrst_rec_num", 64'(rec_num), 64'd0);
    check("midrst_rec_time", 64'(rec_time), 64'd0);
    check("midrst_err_cnt", 64'(err_cnt), 64'd0);
    check("midrst_fifo_rd", 64'(fifo_rd), 64'd0);
    model_reset();
    rst = 1'b0;
    for (int k = 5; k <= 9; k++) push_byte(8'(k));
    push_block(1'b1, 18'($urandom), {4'($urandom), 32'($urandom)});
    wait_idle(200);
    check("midrst_dropped_err", 64'(err_cnt), 64'd5);

    // corruption and resynchronisation
    rst = 1'b1;
    step();
    model_reset();
    rst = 1'b0;
    step();
    push_byte(8'h00);
    push_byte(8'h7E);
    push_block(1'b1, 18'($urandom), {4'($urandom), 32'($urandom)});
    wait_idle(200);
    check("corrupt1_err", 64'(err_cnt), 64'd2);
    push_byte(8'hBF);
    push_byte(8'h01);
    push_block(1'b1, 18'($urandom), {4'($urandom), 32'($urandom)});
    wait_idle(200);
    check("corrupt2_err", 64'(err_cnt), 64'd3);

    // randomized mix with random backpressure and empty stalls
    rand_ready = 1'b1;
    rand_stall = 1'b1;
    for (int it = 0; it < 80; it++) begin
      case ($urandom_range(0, 3))
        0: push_block(1'b1, 18'($urandom), {4'($urandom), 32'($urandom)});
        1: push_block(1'b0, 18'($urandom), 36'd0);
        2: push_byte(8'($urandom_range(0, 255)));
        default: begin
          int need;
          int k;
          need = $urandom_range(0, 1) ? 9 : 3;
          push_byte(need == 9 ? 8'hFF : 8'hBF);
          k = $urandom_range(0, need - 1);
          for (int j = 0; j < k; j++) push_byte({2'b00, 6'($urandom)});
          push_byte({2'($urandom_range(1, 3)), 6'($urandom)});
        end
      endcase
      repeat ($urandom_range(0, 12)) step();
    end
    rand_ready = 1'b0;
    rand_stall = 1'b0;
    rec_ready = 1'b1;
    stall = 1'b0;
    wait_idle(5000);
    check("random_err_cnt", 64'(err_cnt), 64'(m_err));

    // error counter saturation
    for (int n = 0; n < (1 << ERRW) + 5; n++) push_byte(8'h00);
    wait_idle(4000);
    check("sat_err_cnt", 64'(err_cnt), 64'({ERRW{1'b1}}));
    check("sat_err_model", 64'(err_cnt), 64'(m_err));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
